// File: rtl/aska_spi_pkg.sv
// Shared definitions for the SPI register bank: FSM encoding, command byte layout, R/W opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aska_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_DATA    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT_CS = 3'd4
    } state_e;

    localparam int   CMD_BITS     = 8;
    localparam int   CMD_RW_BIT   = 7;
    localparam int   CMD_ADDR_MSB = 6;
    localparam logic OP_WRITE     = 1'b0;
    localparam logic OP_READ      = 1'b1;

    function automatic logic addr_in_range(input logic [CMD_ADDR_MSB:0] addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

endpackage

// File: rtl/aska_spi_sync.sv
// 2-flop synchronizer with rise/fall detection on the synchronized level.
// Latency: q_o 2 clk after d_i; edge pulses 1 clk wide, coincident with the new q_o level.
// Backpressure: none. Flops are deliberately unreset so they keep tracking the pins through reset.
module aska_spi_sync (
    input  logic clk,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        meta_q <= d_i;
        sync_q <= meta_q;
        prev_q <= sync_q;
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/aska_spi_regbank.sv
// SPI mode-0 slave register bank: command byte + DW data bits per CS-low frame; optional read-back
// via ASKA_SPI_READBACK_EN. Latency: commit / frame_err about 4 clk after the CS rise.
// Backpressure: none; clk must run at least 4x SPI_Clk.
module aska_spi_regbank
    import aska_spi_pkg::*;
#(
    parameter int              NREG    = 4,
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 SPI_CS,
    input  logic                 SPI_Clk,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic [NREG*DW-1:0]   regs,
    output logic [NREG-1:0]      wr_stb,
    output logic                 frame_err
);

    localparam logic [6:0] CMD_LAST  = 7'(CMD_BITS - 1);
    localparam logic [6:0] DATA_LAST = 7'(DW - 1);

    logic cs_q, mosi_q, sclk_rise, sclk_fall;
    logic unused_cs_rise, unused_cs_fall, unused_mosi_rise, unused_mosi_fall, unused_sclk_lvl;

    aska_spi_sync u_sync_cs   (.clk(clk), .d_i(SPI_CS),   .q_o(cs_q),
                               .rise_o(unused_cs_rise),   .fall_o(unused_cs_fall));
    aska_spi_sync u_sync_mosi (.clk(clk), .d_i(SPI_MOSI), .q_o(mosi_q),
                               .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall));
    aska_spi_sync u_sync_sclk (.clk(clk), .d_i(SPI_Clk),  .q_o(unused_sclk_lvl),
                               .rise_o(sclk_rise),        .fall_o(sclk_fall));

    state_e          state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [DW-1:0]   data_q, data_d;
    logic            ovl_q, ovl_d;
    logic [NREG-1:0] wr_stb_q, wr_stb_d;
    logic            frame_err_q, frame_err_d;
    logic [DW-1:0]   regs_q [NREG];
    logic            cmd_write, cmd_addr_ok;

    assign cmd_write   = cmd_q[CMD_RW_BIT] == OP_WRITE;
    assign cmd_addr_ok = addr_in_range(cmd_q[CMD_ADDR_MSB:0], NREG);

    // CS high is tested before any clock edge so a coincident SPI_Clk rise is dropped.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        data_d      = data_q;
        ovl_d       = ovl_q;
        wr_stb_d    = '0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!cs_q) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                if (cs_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    cmd_d = {cmd_q[6:0], mosi_q};
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == CMD_LAST) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (cs_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                end else if (sclk_rise) begin
                    data_d = {data_q[DW-2:0], mosi_q};
                    cnt_d  = cnt_q + 7'd1;
                    if (cnt_q == DATA_LAST) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (cs_q) begin
                    state_d = ST_IDLE;
                    if (!cmd_addr_ok) begin
                        frame_err_d = 1'b1;
                    end else if (cmd_write) begin
                        for (int k = 0; k < NREG; k++) begin
                            wr_stb_d[k] = int'(cmd_q[CMD_ADDR_MSB:0]) == k;
                        end
                    end
                end else if (sclk_rise) begin
                    state_d = ST_WAIT_CS;
                    ovl_d   = 1'b1;
                end
            end
            ST_WAIT_CS: begin
                // Also the post-reset state: only an overlong frame owes a frame_err here.
                if (cs_q) begin
                    state_d     = ST_IDLE;
                    frame_err_d = ovl_q;
                    ovl_d       = 1'b0;
                end
            end
            default: state_d = ST_WAIT_CS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_CS;
            cnt_q       <= '0;
            cmd_q       <= '0;
            data_q      <= '0;
            ovl_q       <= 1'b0;
            wr_stb_q    <= '0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < NREG; k++) regs_q[k] <= RST_VAL;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            data_q      <= data_d;
            ovl_q       <= ovl_d;
            wr_stb_q    <= wr_stb_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < NREG; k++) begin
                if (wr_stb_d[k]) regs_q[k] <= data_q;
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_regs
        assign regs[g*DW +: DW] = regs_q[g];
    end
    assign wr_stb    = wr_stb_q;
    assign frame_err = frame_err_q;

`ifdef ASKA_SPI_READBACK_EN
    logic [DW-1:0] rd_sh_q, rd_sh_d, rd_sel;
    logic [6:0]    nxt_addr;
    logic          miso_q, miso_d, rd_active;

    assign nxt_addr = {cmd_q[5:0], mosi_q};

    // The fall right after the last command bit is skipped: MSB is already on the pin.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NREG; k++) begin
            if (int'(nxt_addr) == k) rd_sel = regs_q[k];
        end
        rd_sh_d = rd_sh_q;
        if (state_q == ST_CMD && !cs_q && sclk_rise && cnt_q == CMD_LAST) begin
            rd_sh_d = rd_sel;
        end else if (state_q == ST_DATA && !cs_q && sclk_fall && cnt_q != '0) begin
            rd_sh_d = {rd_sh_q[DW-2:0], 1'b0};
        end
        rd_active = state_q == ST_DATA && cmd_q[CMD_RW_BIT] == OP_READ && cmd_addr_ok;
        miso_d    = rd_active && rd_sh_q[DW-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sh_q <= '0;
            miso_q  <= 1'b0;
        end else begin
            rd_sh_q <= rd_sh_d;
            miso_q  <= miso_d;
        end
    end

    assign SPI_MISO = miso_q;
`else
    logic unused_sclk_fall;
    assign unused_sclk_fall = sclk_fall;
    assign SPI_MISO         = 1'b0;
`endif

endmodule

// File: tb/tb_aska_spi_regbank.sv
// Scoreboard bench for aska_spi_regbank (NREG=4, DW=32, clk 20x SPI_Clk).
// Expected wr_stb/frame_err/read-word events are queued per frame and popped as the DUT produces them.
module tb_aska_spi_regbank;

    localparam int          NREG = 4;
    localparam int          DW   = 32;
    localparam logic [31:0] RV   = 32'h1234_5678;
    localparam int          HP   = 100;
    localparam int          EV_WR = 1, EV_ERR = 2, EV_RD = 3;

    logic clk = 1'b0;
    logic reset, SPI_CS, SPI_Clk, SPI_MOSI, SPI_MISO, frame_err;
    logic [NREG*DW-1:0] regs;
    logic [NREG-1:0]    wr_stb;

    aska_spi_regbank #(.NREG(NREG), .DW(DW), .RST_VAL(RV)) dut (
        .clk(clk), .reset(reset), .SPI_CS(SPI_CS), .SPI_Clk(SPI_Clk), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .regs(regs), .wr_stb(wr_stb), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              kind;
        logic [NREG-1:0] stb;
        logic [63:0]     dat;
    } ev_t;

    ev_t         exp_q[$];
    logic [31:0] model [NREG];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [NREG-1:0] stb, input logic [63:0] dat);
        ev_t e;
        e.kind = kind;
        e.stb  = stb;
        e.dat  = dat;
        exp_q.push_back(e);
    endtask

    task automatic sb_observe(input int kind, input logic [NREG-1:0] stb, input logic [63:0] dat);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", 64'(kind), 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("sb_kind", 64'(kind), 64'(e.kind));
        check("sb_stb", 64'(stb), 64'(e.stb));
        check("sb_dat", dat, e.dat);
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        logic [NREG-1:0] s;
        s    = '0;
        s[a] = 1'b1;
        push_ev(EV_WR, s, {32'h0, d});
        model[a] = d;
    endtask

    function automatic logic [63:0] rd_val(input int a);
`ifdef ASKA_SPI_READBACK_EN
        return {32'h0, model[a]};
`else
        return 64'(a) & 64'd0;
`endif
    endfunction

    // DUT-side outputs: every strobe or error pulse is one scoreboard event.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_stb != '0) begin
                    logic [63:0] d;
                    d = '0;
                    for (int k = 0; k < NREG; k++) begin
                        if (wr_stb[k]) d = {32'h0, regs[k*DW +: DW]};
                    end
                    sb_observe(EV_WR, wr_stb, d);
                end
                if (frame_err) sb_observe(EV_ERR, '0, 64'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regs"}, 64'(regs == {NREG{RV}}), 64'd1);
        check({tag, "_wr_stb"}, 64'(wr_stb), 64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_miso"}, 64'(SPI_MISO), 64'd0);
    endtask

    // One CS-low frame; optionally pulses reset just before bit index rst_at.
    task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] dat, input int ndat,
                             input int rst_at);
        logic [63:0] rd;
        logic        cmd_miso;
        rd       = '0;
        cmd_miso = 1'b0;
        @(negedge clk);
        SPI_CS = 1'b0;
        #(HP);
        for (int i = 0; i < 8 + ndat; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                repeat (4) @(negedge clk);
                check_reset_outputs("midframe_rst");
                reset = 1'b0;
                @(negedge clk);
                for (int k = 0; k < NREG; k++) model[k] = RV;
            end
            SPI_MOSI = (i < 8) ? cmd[7-i] : dat[ndat-1-(i-8)];
            #(HP);
            if (i >= 8) rd = {rd[62:0], SPI_MISO};
            else        cmd_miso = cmd_miso | SPI_MISO;
            SPI_Clk = 1'b1;
            #(HP);
            SPI_Clk = 1'b0;
        end
        #(HP);
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        repeat (30) @(negedge clk);
        check("miso_cmd_phase", 64'(cmd_miso), 64'd0);
        sb_observe(EV_RD, '0, rd);
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [63:0] dat, input int ndat,
                         input int rst_at, input logic [63:0] rd_exp);
        push_ev(EV_RD, '0, rd_exp);
        spi_frame(cmd, dat, ndat, rst_at);
        for (int k = 0; k < NREG; k++) begin
            check($sformatf("regs%0d", k), {32'h0, regs[k*DW +: DW]}, {32'h0, model[k]});
        end
        check("sb_drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        SPI_CS   = 1'b1;
        SPI_Clk  = 1'b0;
        SPI_MOSI = 1'b0;
        for (int k = 0; k < NREG; k++) model[k] = RV;
        repeat (6) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        push_wr(0, 32'hAABB_CCDD);
        frame(8'h00, 64'hAABB_CCDD, 32, -1, 64'd0);

        push_ev(EV_ERR, '0, 64'd0);
        frame(8'h03, 64'h0011_2233, 24, -1, 64'd0);

        push_wr(1, 32'h3377_EEFF);
        frame(8'h01, 64'h3377_EEFF, 32, -1, 64'd0);
        frame(8'h81, 64'hFFFF_FFFF, 32, -1, rd_val(1));

        push_ev(EV_ERR, '0, 64'd0);
        frame(8'h05, 64'hCAFE_BABE, 32, -1, 64'd0);
        push_ev(EV_ERR, '0, 64'd0);
        frame(8'h04, 64'h0BAD_0BAD, 32, -1, 64'd0);

        push_ev(EV_ERR, '0, 64'd0);
        frame(8'h02, 64'h1_5555_AAAA, 33, -1, 64'd0);

        push_ev(EV_ERR, '0, 64'd0);
        frame(8'h85, 64'd0, 32, -1, 64'd0);
        frame(8'h80, 64'd0, 32, -1, rd_val(0));

        frame(8'h02, 64'h1111_2222, 32, 16, 64'd0);
        push_wr(2, 32'hBEBE_CACA);
        frame(8'h02, 64'hBEBE_CACA, 32, -1, 64'd0);

        for (int r = 0; r < 4; r++) begin
            int          a;
            logic [31:0] d;
            a = int'($urandom_range(0, NREG - 1));
            d = $urandom();
            push_wr(a, d);
            frame({1'b0, 7'(a)}, {32'h0, d}, 32, -1, 64'd0);
        end
        for (int a = 0; a < NREG; a++) begin
            frame({1'b1, 7'(a)}, 64'd0, 32, -1, rd_val(a));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
